// File: rtl/class_score_accumulator_pkg.sv
// Shared definitions for the output-layer score accumulator and the argmax stage
// that consumes its packed score bus.
package class_score_accumulator_pkg;

  localparam int NUM_CLASSES      = 10;
  localparam int NUM_SIZE_DEFAULT = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/class_score_accumulator_sat_mac_lane.sv
// One class lane: signed multiply, sign-extended saturating accumulate, and a
// per-beat saturation indication.
module class_score_accumulator_sat_mac_lane
  import class_score_accumulator_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEFAULT,
  parameter int ACT_W    = 10,
  parameter int WT_W     = 10
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       beat_i,
  input  logic signed [NUM_SIZE-1:0] init_i,
  input  logic signed [ACT_W-1:0]    act_i,
  input  logic signed [WT_W-1:0]     wt_i,
  output logic signed [NUM_SIZE-1:0] acc_o,
  output logic                       sat_o
);

  localparam int PROD_W = ACT_W + WT_W;
  localparam int SUM_W  = NUM_SIZE + 1;
  localparam logic signed [NUM_SIZE-1:0] ACC_MAX = {1'b0, {(NUM_SIZE-1){1'b1}}};
  localparam logic signed [NUM_SIZE-1:0] ACC_MIN = {1'b1, {(NUM_SIZE-1){1'b0}}};

  logic signed [PROD_W-1:0]   prod;
  logic signed [SUM_W-1:0]    prod_ext;
  logic signed [SUM_W-1:0]    sum;
  logic signed [NUM_SIZE-1:0] acc_q, acc_d;

  assign prod     = act_i * wt_i;
  assign prod_ext = SUM_W'(prod);
  assign sum      = SUM_W'(acc_q) + prod_ext;

  // The two top bits of the widened sum disagree exactly when the result left
  // the NUM_SIZE range; the extra sign bit tells which rail to clamp to.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_d = acc_q;
    sat_o = 1'b0;
    if (clear_i) begin
      acc_d = init_i;
    end else if (beat_i) begin
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
        sat_o = 1'b1;
        acc_d = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[NUM_SIZE-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/class_score_accumulator.sv
// Output-layer MAC stage feeding the 10-way argmax. Optional build macro
// SCORE_BIAS_EN adds a bias port whose values preload the accumulators at start.
module class_score_accumulator
  import class_score_accumulator_pkg::*;
#(
  parameter int NUM_SIZE   = NUM_SIZE_DEFAULT,
  parameter int ACT_W      = 10,
  parameter int WT_W       = 10,
  parameter int NUM_INPUTS = 64
) (
  input  logic                            clk,
  input  logic                            GlobalReset,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [ACT_W-1:0]         act,
  input  logic [NUM_CLASSES*WT_W-1:0]     weights,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_CLASSES*NUM_SIZE-1:0] Num,
  output logic                            sat_flag
`ifdef SCORE_BIAS_EN
  ,
  input  logic [NUM_CLASSES*NUM_SIZE-1:0] bias
`endif
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             sat_q;

  logic                       beat;
  logic                       clear;
  logic [NUM_CLASSES-1:0]     lane_sat;
  logic signed [NUM_SIZE-1:0] lane_acc  [NUM_CLASSES];
  logic signed [NUM_SIZE-1:0] lane_init [NUM_CLASSES];

  // in_ready_q is high exactly while in ACCUM, so it doubles as the beat gate.
  assign beat  = in_valid && in_ready_q;
  assign clear = (state_q == ST_IDLE) && start;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
`ifdef SCORE_BIAS_EN
    assign lane_init[k] = bias[NUM_SIZE*k +: NUM_SIZE];
`else
    assign lane_init[k] = '0;
`endif

    class_score_accumulator_sat_mac_lane #(
      .NUM_SIZE (NUM_SIZE),
      .ACT_W    (ACT_W),
      .WT_W     (WT_W)
    ) u_lane (
      .clk     (clk),
      .rst_i   (GlobalReset),
      .clear_i (clear),
      .beat_i  (beat),
      .init_i  (lane_init[k]),
      .act_i   (act),
      .wt_i    (weights[WT_W*k +: WT_W]),
      .acc_o   (lane_acc[k]),
      .sat_o   (lane_sat[k])
    );

    assign Num[NUM_SIZE*k +: NUM_SIZE] = lane_acc[k];
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (|lane_sat) sat_q <= 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q     <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_class_score_accumulator.sv
// Directed bench for class_score_accumulator: a 4-beat/26-bit instance for the
// main function and a 64-beat/20-bit instance for saturation.
module tb_class_score_accumulator;

  localparam int NC   = 10;
  localparam int AW   = 10;
  localparam int WW   = 10;
  localparam int NS_A = 26;
  localparam int NS_B = 20;
  localparam int NI_A = 4;
  localparam int NI_B = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst       = 1'b1;
  logic                 start_a   = 1'b0;
  logic                 start_b   = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [AW-1:0] act       = '0;
  logic [NC*WW-1:0]     weights   = '0;

  logic               in_ready_a, out_valid_a, sat_a;
  logic               in_ready_b, out_valid_b, sat_b;
  logic [NC*NS_A-1:0] num_a;
  logic [NC*NS_B-1:0] num_b;
`ifdef SCORE_BIAS_EN
  logic [NC*NS_A-1:0] bias_a = '0;
  logic [NC*NS_B-1:0] bias_b = '0;
`endif

  class_score_accumulator #(
    .NUM_SIZE(NS_A), .ACT_W(AW), .WT_W(WW), .NUM_INPUTS(NI_A)
  ) dut_a (
    .clk(clk), .GlobalReset(rst), .start(start_a), .in_valid(in_valid),
    .in_ready(in_ready_a), .act(act), .weights(weights),
    .out_valid(out_valid_a), .out_ready(out_ready), .Num(num_a),
    .sat_flag(sat_a)
`ifdef SCORE_BIAS_EN
    , .bias(bias_a)
`endif
  );

  class_score_accumulator #(
    .NUM_SIZE(NS_B), .ACT_W(AW), .WT_W(WW), .NUM_INPUTS(NI_B)
  ) dut_b (
    .clk(clk), .GlobalReset(rst), .start(start_b), .in_valid(in_valid),
    .in_ready(in_ready_b), .act(act), .weights(weights),
    .out_valid(out_valid_b), .out_ready(out_ready), .Num(num_b),
    .sat_flag(sat_b)
`ifdef SCORE_BIAS_EN
    , .bias(bias_b)
`endif
  );

  typedef struct {
    int a;
    int w[NC];
    int e[NC];
  } vec_t;

  vec_t tbl[3];
  int   wv[NC];
  int   ev[NC];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] sa(input int k);
    logic signed [NS_A-1:0] t;
    t = num_a[NS_A*k +: NS_A];
    return t;
  endfunction

  function automatic logic signed [63:0] sb(input int k);
    logic signed [NS_B-1:0] t;
    t = num_b[NS_B*k +: NS_B];
    return t;
  endfunction

  task automatic set_w(input int w[NC]);
    for (int k = 0; k < NC; k++) weights[WW*k +: WW] = WW'(w[k]);
  endtask

  // Starts dut_a, feeds NI_A back-to-back beats and checks out_valid timing.
  task automatic run_pass_a(input int a, input int w[NC]);
    act = AW'(a);
    set_w(w);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_in_ready", in_ready_a, 1);
    in_valid = 1'b1;
    for (int j = 0; j < NI_A; j++) begin
      tick();
      check("latency_out_valid", out_valid_a, (j == NI_A - 1));
    end
    in_valid = 1'b0;
  endtask

  task automatic check_scores_a(input string tag, input int e[NC]);
    for (int k = 0; k < NC; k++) check($sformatf("%s[%0d]", tag, k), sa(k), e[k]);
  endtask

  task automatic finish_pass_a();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handshake_out_valid", out_valid_a, 0);
  endtask

  initial begin
    // act, weights, and the hand-derived 4-beat score for each class
    for (int k = 0; k < NC; k++) begin
      tbl[0].a = 1;   tbl[0].w[k] = k;                      tbl[0].e[k] = 4 * k;
      tbl[1].a = -3;  tbl[1].w[k] = k - 5;                  tbl[1].e[k] = 60 - 12 * k;
      tbl[2].a = 511; tbl[2].w[k] = (k % 2 == 0) ? 511 : -512;
      tbl[2].e[k] = (k % 2 == 0) ? 1044484 : -1046528;
    end

    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready_a", in_ready_a, 0);
    check("rst_out_valid_a", out_valid_a, 0);
    check("rst_sat_a", sat_a, 0);
    check("rst_num_a_nonzero", |num_a, 0);
    check("rst_in_ready_b", in_ready_b, 0);
    check("rst_num_b_nonzero", |num_b, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      run_pass_a(tbl[i].a, tbl[i].w);
      check_scores_a($sformatf("tbl%0d_score", i), tbl[i].e);
      check("tbl_sat", sat_a, 0);
      check("tbl_done_in_ready", in_ready_a, 0);
      if (i == 0) begin
        int best = 0;
        for (int k = 1; k < NC; k++) if (sa(k) > sa(best)) best = k;
        check("argmax_index", best, 9);
      end
      finish_pass_a();
      check("score_held_after_done", sa(9), tbl[i].e[9]);
    end

    // Stalls: only accepted beats accumulate, scores frozen when in_valid=0.
    for (int k = 0; k < NC; k++) wv[k] = (k == 2) ? 5 : 0;
    set_w(wv);
    act = 10'sd3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      check($sformatf("stall_score2_c%0d", i), sa(2), 15 * (i / 2 + 1));
    end
    in_valid = 1'b0;
    check("stall_out_valid", out_valid_a, 1);
    for (int k = 0; k < NC; k++) ev[k] = (k == 2) ? 60 : 0;
    check_scores_a("stall_score", ev);
    finish_pass_a();

    // start ignored in ACCUM and DONE; outputs hold while out_ready=0.
    for (int k = 0; k < NC; k++) wv[k] = 1;
    set_w(wv);
    act = 10'sd2;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    in_valid = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    check("hold_out_valid_rise", out_valid_a, 1);
    for (int c = 0; c < 5; c++) begin
      start_a = 1'b1;
      tick();
      check("hold_out_valid", out_valid_a, 1);
      check("hold_in_ready", in_ready_a, 0);
      check("hold_score3", sa(3), 8);
    end
    out_ready = 1'b1;
    tick();
    start_a   = 1'b0;
    out_ready = 1'b0;
    check("hold_release_out_valid", out_valid_a, 0);
    tick();
    check("start_on_handshake_ignored", in_ready_a, 0);
    for (int k = 0; k < NC; k++) ev[k] = 8;
    check_scores_a("hold_score", ev);

    // Reset in the middle of a pass aborts it with no partial output.
    for (int k = 0; k < NC; k++) wv[k] = k;
    set_w(wv);
    act = 10'sd1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_in_ready", in_ready_a, 0);
    check("midrst_num_nonzero", |num_a, 0);
    run_pass_a(tbl[0].a, tbl[0].w);
    check_scores_a("postrst_score", tbl[0].e);
    finish_pass_a();

    // Bias preload (zero weights): bias shows through only in the bias build.
    for (int k = 0; k < NC; k++) wv[k] = 0;
`ifdef SCORE_BIAS_EN
    bias_a[NS_A*5 +: NS_A] = 26'sd100;
`endif
    run_pass_a(7, wv);
    for (int k = 0; k < NC; k++) ev[k] = 0;
`ifdef SCORE_BIAS_EN
    ev[5] = 100;
`endif
    check_scores_a("bias_score", ev);
    finish_pass_a();
`ifdef SCORE_BIAS_EN
    bias_a = '0;
`endif

    // Saturation on the 20-bit instance: +clamp on lane 0, -clamp on lane 1.
    for (int k = 0; k < NC; k++) wv[k] = 0;
    wv[0] = -512;
    wv[1] = 511;
    set_w(wv);
    act = -10'sd512;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < NI_B; j++) tick();
    in_valid = 1'b0;
    check("sat_out_valid", out_valid_b, 1);
    check("sat_pos_clamp", sb(0), 524287);
    check("sat_neg_clamp", sb(1), -524288);
    check("sat_idle_lane", sb(2), 0);
    check("sat_flag_set", sat_b, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sat_flag_sticky", sat_b, 1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("sat_flag_cleared", sat_b, 0);
    check("sat_restart_in_ready", in_ready_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/class_score_accumulator.md
Name: class_score_accumulator

Overview:
- Output-layer MAC stage that sits directly upstream of the 10-way argmax comparator.
- Streams one signed input activation per beat, together with the 10 matching signed weights.
- Accumulates 10 signed class scores of NUM_SIZE bits, then presents them as the packed 10×NUM_SIZE score bus the argmax consumes, with a valid/ready handshake.

Parameters:
- NUM_SIZE, 26, width of each class score; must match the argmax NUM_SIZE.
- ACT_W, 10, signed activation width.
- WT_W, 10, signed weight width.
- NUM_INPUTS, 64, beats per classification (≥1).

Ports:
- clk  in  1  clock, rising edge.
- GlobalReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new classification (honoured in IDLE only).
- in_valid  in  1  act/weights valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- act  in  ACT_W  signed activation.
- weights  in  10*WT_W  signed weight for class k at [WT_W*k +: WT_W].
- out_valid  out  1  score bus valid.
- out_ready  in  1  consumer accepts scores.
- Num  out  10*NUM_SIZE  signed score k at [NUM_SIZE*k +: NUM_SIZE].
- sat_flag  out  1  sticky: any accumulator saturated this classification.
- bias  in  10*NUM_SIZE  per-class bias; exists only with SCORE_BIAS_EN.

Behaviour:
- Reset values (GlobalReset=1 at a clk edge): state=IDLE, all accumulators=0, beat counter=0, in_ready=0, out_valid=0, sat_flag=0, Num=0.
- Reset has priority over every other input and aborts any operation in progress with no partial output.
- States and transitions:
  - IDLE: in_ready=0, out_valid=0. On start=1, clear accumulators (or load bias), clear counter and sat_flag, go to ACCUM.
  - ACCUM: in_ready=1. On each accepted beat, for every k, acc[k] <= sat(acc[k] + sext(act*weights[k])). Counter increments. If counter==NUM_INPUTS-1 on an accepted beat, go to DONE next cycle. in_valid=0 stalls with no state change. start is ignored.
  - DONE: in_ready=0, out_valid=1, Num=accumulators, held stable until out_ready=1. On out_valid && out_ready, go to IDLE; accumulators keep their values and Num continues to show them.
- Latency: out_valid rises exactly 1 cycle after the last accepted beat. Best case is NUM_INPUTS+1 cycles from start.
- Arithmetic:
  - Product is a full-precision signed ACT_W+WT_W bit value (20b), sign-extended to NUM_SIZE+1.
  - The sum is formed in NUM_SIZE+1 bits and clamped to [-2^(NUM_SIZE-1), 2^(NUM_SIZE-1)-1].
  - A clamp sets sat_flag, which stays set until the next start.
- start asserted on the same cycle as the DONE→IDLE handshake is ignored, because the state is not yet IDLE.
- Counter width is $clog2(NUM_INPUTS+1). NUM_INPUTS=1 goes ACCUM→DONE after a single beat.
- Num is driven directly from registers, with no combinational path from inputs. It feeds the combinational argmax directly.

Optional Feature:
- Macro: SCORE_BIAS_EN.
- Defined: bias port present; the IDLE→ACCUM transition loads acc[k] <= bias[k].
- Undefined: no bias port; accumulators clear to 0 at start.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package/header:
  - NUM_CLASSES=10.
  - State encodings: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Shared NUM_SIZE default 26, shared with the argmax stage.
- One sub-module, sat_mac_lane: one class lane holding the accumulator register, multiply, and saturating add, plus a saturation output. It is instantiated 10 times via generate.

Test Plan:
- NUM_INPUTS=4, act=1 every beat, weights[k]=k → Num[k]=4k. out_valid is 1 exactly one cycle after the 4th beat. Downstream argmax index = 9.
- in_valid toggled 1,0,1,0,… with act=3 and weights[2]=5, others 0 → only accepted beats count. Num[2]=60, others 0. Scores are unchanged during stall cycles.
- act=-512, weights[0]=-512 for 64 beats with NUM_SIZE=20 → Num[0] clamps to 524287 and sat_flag=1. The next start clears sat_flag.
- out_ready held 0 for 5 cycles in DONE → Num and out_valid stable, in_ready=0. start pulses during ACCUM/DONE are ignored.
- GlobalReset asserted after beat 2 of 4 → next cycle: IDLE, Num=0, out_valid=0. A new start runs a clean 4-beat pass with correct sums.
- With SCORE_BIAS_EN: bias[5]=100, all weights 0 → Num[5]=100, others 0. Without the macro the same stimulus gives all zeros.
